m68k_bus_master: RTL and testbench

M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

---
 rtl/m68k_bus_master.sv | 167 ++++++++++++++++
 tb/tb_m68k_bus_master.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_master.sv
// 68000-style bus master: S0..S7 cycle with DTACK/VPA/BERR termination, a
// free-running E clock for VPA (6800-style) cycles, and a bus-error timeout.
`timescale 1ns/1ps
module m68k_bus_master (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        req,
  input  logic        rw,
  input  logic [22:0] addr,
  input  logic [1:0]  be,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [22:0] A,
  output logic [15:0] D_out,
  output logic        D_oe,
  output logic        bus_oe,
  output logic        nAS,
  output logic        nUDS,
  output logic        nLDS,
  output logic        RW,
  output logic        E,
  output logic        nVMA,
  input  logic [15:0] D_in,
  input  logic        nDTACK,
  input  logic        nVPA,
  input  logic        nBERR,
  input  logic        nBGACK
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_S0    = 4'd1;
  localparam logic [3:0] ST_S1    = 4'd2;
  localparam logic [3:0] ST_S2    = 4'd3;
  localparam logic [3:0] ST_S3    = 4'd4;
  localparam logic [3:0] ST_S4    = 4'd5;
  localparam logic [3:0] ST_S5    = 4'd6;
  localparam logic [3:0] ST_S6    = 4'd7;
  localparam logic [3:0] ST_S7    = 4'd8;
  localparam logic [3:0] ST_W     = 4'd9;
  localparam logic [3:0] ST_VWAIT = 4'd10;

  logic [3:0]  r_state;
  logic [3:0]  w_nxt;
  logic        r_rw;
  logic [22:0] r_addr;
  logic [1:0]  r_be;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_fail;
  logic [4:0]  r_ecnt;
  logic [4:0]  w_ecnt_nxt;
  logic        r_e;
  logic        r_nvma;
  logic [7:0]  r_tmo;
  logic [1:0]  r_dtack_s;
  logic [1:0]  r_vpa_s;
  logic [1:0]  r_berr_s;

  logic w_start, w_dtack, w_vpa, w_tmo_hit, w_berr, w_fail_set, w_vpa_done;
  logic w_waiting, w_as_act, w_ds_act;

  assign w_start    = (r_state == ST_IDLE) && req && nBGACK && (be != 2'b00);
  assign w_dtack    = ~r_dtack_s[1];
  assign w_vpa      = ~r_vpa_s[1];
  assign w_tmo_hit  = (r_tmo == 8'hFF);
  // A timeout is treated exactly like an asserted BERR.
  assign w_berr     = ~r_berr_s[1] | w_tmo_hit;
  assign w_waiting  = (r_state == ST_S4) || (r_state == ST_W) || (r_state == ST_VWAIT);
  assign w_vpa_done = (r_state == ST_VWAIT) && !w_berr && (r_ecnt == 5'd19) && !r_nvma;
  assign w_fail_set = ((r_state == ST_S4) && w_berr) || ((r_state == ST_W) && w_tmo_hit) ||
                      ((r_state == ST_VWAIT) && w_berr);
  assign w_ecnt_nxt = (r_ecnt == 5'd19) ? 5'd0 : r_ecnt + 5'd1;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start) w_nxt = ST_S0;
      ST_S0:    w_nxt = ST_S1;
      ST_S1:    w_nxt = ST_S2;
      ST_S2:    w_nxt = ST_S3;
      ST_S3:    w_nxt = ST_S4;
      ST_S4: begin
        if (w_berr)       w_nxt = ST_S7;
        else if (w_dtack) w_nxt = ST_S5;
        else if (w_vpa)   w_nxt = ST_VWAIT;
        else              w_nxt = ST_W;
      end
      ST_W:     w_nxt = w_tmo_hit ? ST_S7 : ST_S4;
      ST_S5:    w_nxt = ST_S6;
      ST_S6:    w_nxt = ST_S7;
      ST_S7:    w_nxt = ST_IDLE;
      ST_VWAIT: if (w_berr || w_vpa_done) w_nxt = ST_S7;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state   <= ST_IDLE;
      r_rw      <= 1'b1;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_fail    <= 1'b0;
      r_ecnt    <= '0;
      r_e       <= 1'b0;
      r_nvma    <= 1'b1;
      r_tmo     <= '0;
      r_dtack_s <= 2'b11;
      r_vpa_s   <= 2'b11;
      r_berr_s  <= 2'b11;
    end else begin
      r_state   <= w_nxt;
      r_dtack_s <= {r_dtack_s[0], nDTACK};
      r_vpa_s   <= {r_vpa_s[0], nVPA};
      r_berr_s  <= {r_berr_s[0], nBERR};
      r_ecnt    <= w_ecnt_nxt;
      r_e       <= (w_ecnt_nxt >= 5'd12);
      if (w_start) begin
        r_rw    <= rw;
        r_addr  <= addr;
        r_be    <= be;
        r_wdata <= wdata;
        r_fail  <= 1'b0;
      end else if (w_fail_set) begin
        r_fail  <= 1'b1;
      end
      if (r_state == ST_S2)
        r_tmo <= '0;
      else if (w_waiting && !w_tmo_hit)
        r_tmo <= r_tmo + 8'd1;
      // VMA is held only across the E-high phase that completes the VPA cycle.
      if ((r_state == ST_VWAIT) && (r_ecnt == 5'd11))
        r_nvma <= 1'b0;
      else if (((r_state == ST_VWAIT) && (w_nxt != ST_VWAIT)) || (r_state == ST_IDLE))
        r_nvma <= 1'b1;
      if (r_rw && (((r_state == ST_S6)) || w_vpa_done))
        r_rdata <= D_in;
    end
  end

  assign w_as_act = (r_state == ST_S2) || (r_state == ST_S3) || (r_state == ST_S4) ||
                    (r_state == ST_S5) || (r_state == ST_S6) || w_waiting;
  assign w_ds_act = r_rw ? w_as_act
                         : ((r_state == ST_S5) || (r_state == ST_S6) || w_waiting);

  assign busy   = (r_state != ST_IDLE);
  assign bus_oe = (r_state != ST_IDLE);
  assign RW     = (r_state == ST_IDLE) ? 1'b1 : r_rw;
  assign A      = r_addr;
  assign D_out  = r_wdata;
  assign D_oe   = !r_rw && (r_state != ST_IDLE) && (r_state != ST_S0) &&
                  (r_state != ST_S1) && (r_state != ST_S2);
  assign nAS    = ~w_as_act;
  assign nUDS   = ~(w_ds_act & r_be[1]);
  assign nLDS   = ~(w_ds_act & r_be[0]);
  assign ack    = (r_state == ST_S7) && !r_fail;
  assign err    = (r_state == ST_S7) && r_fail;
  assign rdata  = r_rdata;
  assign E      = r_e;
  assign nVMA   = r_nvma;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Randomized bench for m68k_bus_master: every bus cycle is predicted per clk
// from the bus-timing rules and compared signal by signal.
`timescale 1ns/1ps
module tb_m68k_bus_master;
  logic        clk = 1'b0, nRESET = 1'b0, req = 1'b0, rw = 1'b1;
  logic [22:0] addr = '0;
  logic [1:0]  be = '0;
  logic [15:0] wdata = '0, D_in = '0;
  logic        nDTACK = 1'b1, nVPA = 1'b1, nBERR = 1'b1, nBGACK = 1'b1;
  logic [15:0] rdata, D_out;
  logic [22:0] A;
  logic        ack, err, busy, D_oe, bus_oe, nAS, nUDS, nLDS, RW, E, nVMA;

  int n_vec = 0, n_bad = 0, txn = 0, cyc = 0;
  int gc;                  // clk edges since reset release: ecnt == gc % 20
  logic [15:0] m_rdata = '0;

  m68k_bus_master dut (
    .clk(clk), .nRESET(nRESET), .req(req), .rw(rw), .addr(addr), .be(be), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy), .A(A), .D_out(D_out), .D_oe(D_oe),
    .bus_oe(bus_oe), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .RW(RW), .E(E), .nVMA(nVMA),
    .D_in(D_in), .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR), .nBGACK(nBGACK)
  );

  always #35 clk = ~clk;
  always @(posedge clk or negedge nRESET)
    if (!nRESET) gc <= 0; else gc <= gc + 1;

  initial begin
    #(70 * 50000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s txn %0d cyc %0d: got %0h exp %0h", tag, txn, cyc, got, exp);
    end
  endtask

  // Cycle index c counts clks after the edge that accepted req (S0 is c=0).
  // S4 samples the synchronized lines at edges 5,7,9,...; a line driven low
  // during cycle t is first seen at an edge >= t+3 (two synchronizer flops).
  function automatic int vis(input int t);
    int d;
    if (t < 0) return 100000;
    d = (t + 3 > 5) ? t + 3 : 5;
    if (d % 2 == 0) d++;
    return d;
  endfunction

  // c7: cycle index of S7; von/voff bound the nVMA-low window.
  task automatic predict(input int t_dt, input int t_vpa, input int t_berr, input int g0,
                         output int c7, output bit fail, output int von, output int voff);
    int db, dd, dv, dm;
    db = vis(t_berr); dd = vis(t_dt); dv = vis(t_vpa);
    dm = db < dd ? db : dd;
    dm = dv < dm ? dv : dm;
    von = -1; voff = -1; fail = 1'b0; c7 = dm + 2;
    // First waiting clk (count 0) is c=4; count 255 is reached on edge 260.
    if (dm > 260) begin fail = 1'b1; c7 = 260; end
    else if (db == dm) begin fail = 1'b1; c7 = dm; end
    else if (dd == dm) c7 = dm + 2;
    else begin
      for (int e = dm + 1; e < dm + 80; e++) begin
        int pre;
        pre = (g0 + e - 1) % 20;
        if (pre == 11) von = e;
        else if (pre == 19 && von >= 0) begin c7 = e; voff = e; break; end
      end
    end
  endtask

  task automatic run(input logic t_rw, input logic [22:0] t_addr, input logic [1:0] t_be,
                     input logic [15:0] t_wd, input logic [15:0] t_din, input int t_dt,
                     input int t_vpa, input int t_berr, input bit bg_tog, input int rst_at);
    int c7, von, voff, g0;
    bit fail;
    logic ds_lo;
    txn++;
    @(negedge clk);
    req = 1'b1; rw = t_rw; addr = t_addr; be = t_be; wdata = t_wd; D_in = t_din;
    @(negedge clk);
    g0 = gc;
    predict(t_dt, t_vpa, t_berr, g0, c7, fail, von, voff);
    // Inputs change after acceptance; the running cycle must not see it.
    req = 1'b0; rw = $urandom_range(0, 1); addr = $urandom; wdata = $urandom; be = $urandom;
    for (int c = 0; c <= c7 + 1; c++) begin
      if (c > 0) @(negedge clk);
      cyc = c;
      ds_lo = (c >= (t_rw ? 2 : 4)) && (c < c7);
      chk("busy",   busy,   c <= c7);
      chk("bus_oe", bus_oe, c <= c7);
      chk("RW",     RW,     (c <= c7) ? t_rw : 1'b1);
      chk("nAS",    nAS,    !(c >= 2 && c < c7));
      chk("nUDS",   nUDS,   !(ds_lo && t_be[1]));
      chk("nLDS",   nLDS,   !(ds_lo && t_be[0]));
      chk("D_oe",   D_oe,   !t_rw && c >= 3 && c <= c7);
      chk("ack",    ack,    c == c7 && !fail);
      chk("err",    err,    c == c7 && fail);
      chk("E",      E,      ((g0 + c) % 20) >= 12);
      chk("nVMA",   nVMA,   !(von >= 0 && c >= von && c < voff));
      chk("rdata",  rdata,  (c >= c7 && !fail && t_rw) ? t_din : m_rdata);
      if (c <= c7) chk("A", A, t_addr);
      if (!t_rw && c >= 3 && c <= c7) chk("D_out", D_out, t_wd);
      if (c == rst_at) begin
        nRESET = 1'b0; nDTACK = 1'b1; nVPA = 1'b1; nBERR = 1'b1; nBGACK = 1'b1;
        m_rdata = '0;
        #1;
        chk("rst_nAS", {nAS, nUDS, nLDS, nVMA, RW}, 5'b11111);
        chk("rst_oe",  {bus_oe, D_oe, busy, ack, err}, 5'b0);
        chk("rst_rdata", rdata, 16'h0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("rst_quiet", {ack, err, busy, E}, 4'b0);
        end
        nRESET = 1'b1;
        return;
      end
      if (c == t_dt)   nDTACK = 1'b0;
      if (c == t_vpa)  nVPA   = 1'b0;
      if (c == t_berr) nBERR  = 1'b0;
      if (bg_tog && c == 3) nBGACK = 1'b0;
      if (bg_tog && c == 6) nBGACK = 1'b1;
    end
    if (!fail && t_rw) m_rdata = t_din;
    nDTACK = 1'b1; nVPA = 1'b1; nBERR = 1'b1; nBGACK = 1'b1;
  endtask

  // A request that must not start a cycle.
  task automatic reject(input logic [1:0] t_be, input logic t_bg);
    txn++;
    @(negedge clk);
    req = 1'b1; rw = 1'b1; be = t_be; nBGACK = t_bg; addr = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cyc = k;
      chk("rej", {busy, bus_oe, ack, err, nAS}, 5'b00001);
    end
    req = 1'b0; nBGACK = 1'b1;
  endtask

  initial begin
    logic [1:0]  r_be;
    logic [22:0] r_addr;
    int sel, t;
    repeat (3) @(negedge clk);
    chk("reset_strobes", {nAS, nUDS, nLDS, nVMA, RW}, 5'b11111);
    chk("reset_oe", {bus_oe, D_oe, ack, err, busy, E}, 6'b0);
    chk("reset_rdata", rdata, 16'h0);
    nRESET = 1'b1;
    @(negedge clk);

    run(1'b1, 23'h6FF802, 2'b11, 16'h0,    16'h1234, 0, -1, -1, 1'b0, -1); // word read
    run(1'b0, 23'h012345, 2'b01, 16'hAB55, 16'h0,    3, -1, -1, 1'b0, -1); // byte write, 2 waits
    run(1'b1, 23'h5FF000, 2'b11, 16'h0,    16'h00C3, -1, 0, -1, 1'b0, -1); // VPA read
    run(1'b1, 23'h000100, 2'b10, 16'h0,    16'hDEAD, -1, -1, -1, 1'b0, -1); // timeout
    run(1'b1, 23'h000200, 2'b11, 16'h0,    16'hBEEF, 2, -1, 2, 1'b0, -1);   // BERR+DTACK
    run(1'b1, 23'h000300, 2'b11, 16'h0,    16'h5A5A, 0, -1, -1, 1'b0, 5);   // reset in S5
    run(1'b1, 23'h000304, 2'b11, 16'h0,    16'hC001, 0, -1, -1, 1'b1, -1);  // after reset
    reject(2'b00, 1'b1);
    reject(2'b11, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r_be = 2'($urandom_range(1, 3));
      r_addr = 23'($urandom);
      sel = $urandom_range(0, 3);
      t = $urandom_range(0, 12);
      run(1'($urandom_range(0, 1)), r_addr, r_be, 16'($urandom), 16'($urandom),
          (sel == 0 || sel == 3) ? t : -1, (sel == 1) ? t : -1, (sel == 2) ? t : -1,
          1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
